lavatory_lock_conditioner: RTL
==============================

# lavatory_lock_conditioner

Conditions the raw door-lock sensors of the aircraft lavatories before they reach the availability-sign logic. Each sensor (1 = door locked) is synchronised to `clk_2`, debounced by a per-door state machine, and turned into a clean lock level. The block also emits one-cycle lock/unlock event pulses and a per-door saturating occupancy timer. It sits directly upstream of the LED availability logic, between `SWI[NDOORS-1:0]` and that stage.

## Interface
- `NDOORS`, 3, number of lavatories (door 0 = women-only)
- `DEB_CYCLES`, 4, consecutive equal synchronised samples required to accept a change; legal range ≥ 2
- `OCC_BITS`, 8, width of each occupancy timer
- `clk_2`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `door_raw`  in  NDOORS  raw lock sensors, driven from `SWI[NDOORS-1:0]`
- `door_locked`  out  NDOORS  debounced lock level per door
- `lock_pulse`  out  NDOORS  one-cycle pulse when a door becomes locked
- `unlock_pulse`  out  NDOORS  one-cycle pulse when a door becomes unlocked
- `occ_time`  out  NDOORS*OCC_BITS  per-door occupancy cycles; door i occupies bits [i*OCC_BITS +: OCC_BITS]

## Operation
- Each door has 2-flop synchroniser `s1→s2`, a 4-state FSM, and a counter of width `$clog2(DEB_CYCLES)`.
- FSM states:
  - `UNLOCKED`: if `s2=1`, go to `LOCK_PEND` with `cnt=1`.
  - `LOCK_PEND`:
    - if `s2=0`, return to `UNLOCKED` with `cnt=0`.
    - else if `cnt=DEB_CYCLES-1`, go to `LOCKED` with `cnt=0`.
    - else increment `cnt`.
  - `LOCKED`: if `s2=0`, go to `UNLOCK_PEND` with `cnt=1`.
  - `UNLOCK_PEND`: mirror of `LOCK_PEND`.
    - if `s2=1`, return to `LOCKED`.
    - on terminal count, go to `UNLOCKED`.
- `door_locked = 1` in `LOCKED` and `UNLOCK_PEND`. It is registered and glitch-free.
- Event pulses:
  - `lock_pulse[i]` is high for exactly the first cycle of `LOCKED` entered from `LOCK_PEND`.
  - `unlock_pulse[i]` is high for exactly the first cycle of `UNLOCKED` entered from `UNLOCK_PEND`.
  - An aborted pending state produces no pulse.
- Occupancy timer:
  - cleared to 0 in the cycle `lock_pulse` is high.
  - increments by 1 each following cycle while `door_locked=1`.
  - saturates at `2^OCC_BITS-1`.
  - after unlock, holds the last value until the next lock clears it.
- Doors are fully independent. Simultaneous changes on several doors are processed in parallel, with no priority.

## Timing
- Reset (`rst_n=0`, any time, including mid-pending):
  - immediately forces all sync flops, counters and outputs to 0.
  - all FSMs go to `UNLOCKED`.
  - the first accepted edge is after `rst_n` rises.
- Latency: `door_raw[i]` changes before edge 0 and then stays stable.
  - `s1` updates at edge 0; `s2` updates at edge 1; pending state is entered at edge 2.
  - `door_locked[i]` changes at edge `DEB_CYCLES+1`, i.e. the `(DEB_CYCLES+2)`-th edge. With default 4, that is the 6th edge.
  - the pulse is coincident with that change.
- Glitch rejection: any `s2` excursion shorter than `DEB_CYCLES` cycles never changes `door_locked`.
- Occupancy value: at the k-th cycle after `lock_pulse`, `occ_time=min(k, 2^OCC_BITS-1)`.
- No combinational path from `door_raw` to any output. All outputs are flop-driven.

## Structure
- Package `lav_pkg`:
  - `typedef enum logic [1:0] {UNLOCKED, LOCK_PEND, LOCKED, UNLOCK_PEND} lock_state_t`
  - `localparam NDOORS_DEF = 3`
  - `localparam WOMEN_DOOR = 0`
- Sub-module `lav_door_debounce`:
  - contains one door's synchroniser, FSM, counter, pulses and occupancy timer.
  - takes parameters `DEB_CYCLES` and `OCC_BITS`.
  - instantiated `NDOORS` times via generate in `lavatory_lock_conditioner`.

## Test plan
- Reset: drive `door_raw=3'b111` to reach `LOCK_PEND` (no door reaches `LOCKED`), assert `rst_n=0` between clock edges → all outputs 0 immediately with no clock edge; after release, `door_locked` rises on the 6th edge after release.
- Clean lock: default params, `door_raw[1]` 0→1 held → `door_locked[1]` rises at the 6th edge; `lock_pulse[1]` high exactly 1 cycle, coincident; other doors unchanged.
- Glitch: `door_raw[0]=1` for 3 cycles, then 0 → `door_locked`, `lock_pulse` and `occ_time[0]` unchanged throughout.
- Chatter in `UNLOCK_PEND`: door 2 locked; drop raw for 2 cycles, then restore → `door_locked[2]` stays 1; no `unlock_pulse`; `occ_time` keeps counting.
- Saturation: `OCC_BITS=4`, lock door 0 and hold for 20 cycles → `occ_time[0]=15`; unlock → stays 15; relock → 0 in the pulse cycle, then 1, 2, ….
- Simultaneous: all three raw bits 0→1 on the same edge → all `door_locked` rise and all `lock_pulse` fire in the same cycle; release together → all `unlock_pulse` fire in the same cycle.

Source files
------------

// File: rtl/lav_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lav_pkg
//  Purpose  : Shared types and constants for the lavatory lock conditioner.
//  Revision : 1.0  initial release
// ============================================================================
package lav_pkg;

    // Per-door debounce states; LOCKED and UNLOCK_PEND both report "locked".
    typedef enum logic [1:0] {
        UNLOCKED    = 2'd0,
        LOCK_PEND   = 2'd1,
        LOCKED      = 2'd2,
        UNLOCK_PEND = 2'd3
    } lock_state_t;

    localparam int NDOORS_DEF = 3;
    localparam int WOMEN_DOOR = 0;

    // A door is reported locked while stably locked or while an unlock is
    // still being confirmed.
    function automatic logic is_locked_state(input lock_state_t s);
        return (s == LOCKED) || (s == UNLOCK_PEND);
    endfunction

endpackage : lav_pkg
`default_nettype wire

// File: rtl/lav_door_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : lav_door_debounce
//  Purpose  : One door: 2-flop synchroniser, debounce FSM with counter,
//             registered lock level, lock/unlock event pulses and a
//             saturating occupancy timer.
//  Revision : 1.0  initial release
// ============================================================================
module lav_door_debounce
    import lav_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int OCC_BITS   = 8
) (
    input  logic                clk_2,
    input  logic                rst_n,
    input  logic                i_door_raw,
    output logic                o_door_locked,
    output logic                o_lock_pulse,
    output logic                o_unlock_pulse,
    output logic [OCC_BITS-1:0] o_occ_time
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(DEB_CYCLES - 1);
    localparam logic [OCC_BITS-1:0] OCC_MAX = {OCC_BITS{1'b1}};

    // Synchroniser stages
    logic r_s1;
    logic r_s2;

    // FSM, counter and registered outputs
    lock_state_t         r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_locked;
    logic                r_lock_pulse;
    logic                r_unlock_pulse;
    logic [OCC_BITS-1:0] r_occ;

    // Next-state / next-output values
    lock_state_t         w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_locked_nxt;
    logic                w_lock_pulse_nxt;
    logic                w_unlock_pulse_nxt;
    logic [OCC_BITS-1:0] w_occ_nxt;

    // Two-flop synchroniser bringing the raw sensor into clk_2.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_door_raw;
            r_s2 <= r_s1;
        end
    end

    // State register; outputs are registered from their next values so they
    // change on the same edge as the state and never glitch.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= UNLOCKED;
            r_cnt          <= '0;
            r_locked       <= 1'b0;
            r_lock_pulse   <= 1'b0;
            r_unlock_pulse <= 1'b0;
            r_occ          <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_locked       <= w_locked_nxt;
            r_lock_pulse   <= w_lock_pulse_nxt;
            r_unlock_pulse <= w_unlock_pulse_nxt;
            r_occ          <= w_occ_nxt;
        end
    end

    // Next-state logic: a change is accepted only after DEB_CYCLES equal
    // synchronised samples; any contrary sample aborts the pending state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            UNLOCKED: begin
                if (r_s2) begin
                    w_state_nxt = LOCK_PEND;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            LOCK_PEND: begin
                if (!r_s2) begin
                    w_state_nxt = UNLOCKED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TERM) begin
                    w_state_nxt = LOCKED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            LOCKED: begin
                if (!r_s2) begin
                    w_state_nxt = UNLOCK_PEND;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            UNLOCK_PEND: begin
                if (r_s2) begin
                    w_state_nxt = LOCKED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TERM) begin
                    w_state_nxt = UNLOCKED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = UNLOCKED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: lock level, completed-transition pulses (aborted pending
    // states produce none) and the occupancy timer, cleared on the lock pulse
    // and advanced while the door reads locked.
    always_comb begin
        w_locked_nxt       = is_locked_state(w_state_nxt);
        w_lock_pulse_nxt   = (r_state == LOCK_PEND)   && (w_state_nxt == LOCKED);
        w_unlock_pulse_nxt = (r_state == UNLOCK_PEND) && (w_state_nxt == UNLOCKED);
        w_occ_nxt          = r_occ;
        if (w_lock_pulse_nxt) begin
            w_occ_nxt = '0;
        end else if (r_locked && (r_occ != OCC_MAX)) begin
            w_occ_nxt = r_occ + 1'b1;
        end
    end

    assign o_door_locked  = r_locked;
    assign o_lock_pulse   = r_lock_pulse;
    assign o_unlock_pulse = r_unlock_pulse;
    assign o_occ_time     = r_occ;

endmodule : lav_door_debounce
`default_nettype wire

// File: rtl/lavatory_lock_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : lavatory_lock_conditioner
//  Purpose  : Conditions NDOORS raw lavatory lock sensors into debounced lock
//             levels, lock/unlock event pulses and occupancy timers. Doors are
//             processed independently and in parallel.
//  Revision : 1.0  initial release
// ============================================================================
module lavatory_lock_conditioner
    import lav_pkg::*;
#(
    parameter int NDOORS     = NDOORS_DEF,
    parameter int DEB_CYCLES = 4,
    parameter int OCC_BITS   = 8
) (
    input  logic                         clk_2,
    input  logic                         rst_n,
    input  logic [NDOORS-1:0]            door_raw,
    output logic [NDOORS-1:0]            door_locked,
    output logic [NDOORS-1:0]            lock_pulse,
    output logic [NDOORS-1:0]            unlock_pulse,
    output logic [NDOORS*OCC_BITS-1:0]   occ_time
);

    // One independent conditioner per door; no cross-door priority exists.
    generate
        for (genvar gi = 0; gi < NDOORS; gi++) begin : g_door
            lav_door_debounce #(
                .DEB_CYCLES (DEB_CYCLES),
                .OCC_BITS   (OCC_BITS)
            ) u_door (
                .clk_2          (clk_2),
                .rst_n          (rst_n),
                .i_door_raw     (door_raw[gi]),
                .o_door_locked  (door_locked[gi]),
                .o_lock_pulse   (lock_pulse[gi]),
                .o_unlock_pulse (unlock_pulse[gi]),
                .o_occ_time     (occ_time[gi*OCC_BITS +: OCC_BITS])
            );
        end
    endgenerate

endmodule : lavatory_lock_conditioner
`default_nettype wire
